data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the CPU's data-memory strobes. The control unit raises `wmem` or `rmem` for store and load instructions, and this block services those strobes against a single-port word-addressed data RAM. It holds the pipeline with `stall` while an access is in flight and returns load data with a one-cycle `rvalid` pulse. It sits between the execute/memory stage and the RAM array, replacing direct combinational RAM access.

## Interface
- `DATA_W`, 32: data word width.
- `ADDR_W`, 10: word-address width; depth is 2**ADDR_W, so no address is out of range.
- `RD_LAT`, 2: read stall cycles, legal range 1..7.

- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wmem`  in  1  store request from the control unit.
- `rmem`  in  1  load request from the control unit.
- `addr`  in  ADDR_W  word address; sampled when a request is accepted.
- `wdata`  in  DATA_W  store data; sampled when a request is accepted.
- `rdata`  out  DATA_W  load result; holds its value until the next load completes.
- `rvalid`  out  1  one-cycle pulse when `rdata` is updated.
- `stall`  out  1  block busy; the pipeline must hold its request while this is 1.
- `err`  out  1  one-cycle pulse for an illegal request (`wmem` and `rmem` both high).

## Operation
- Outputs are registered. Reset values: `rdata`=0, `rvalid`=0, `stall`=0, `err`=0, state=IDLE.
- FSM states: IDLE, RD_WAIT, WR.
- A request is accepted only in IDLE, on a cycle where `stall`=0.
- IDLE transitions:
  - `rmem` & !`wmem`: latch `addr`, go to RD_WAIT, load the counter with RD_LAT-1.
  - `wmem` & !`rmem`: latch `addr`/`wdata`, go to WR (buffered mode: see Configuration).
  - both high: `err`=1 next cycle, no access, stay in IDLE.
  - neither: stay in IDLE.
- RD_WAIT:
  - `stall`=1 throughout.
  - The counter decrements each cycle.
  - At count 0, the array is read at the latched address into `rdata`, then go to IDLE with `rvalid`=1.
- WR: `stall`=1; the array is written at the end of this cycle; go to IDLE.
- Inputs are ignored outside IDLE.
- Reset mid-operation:
  - Any in-flight access is abandoned.
  - All outputs return to reset values.
  - Array contents are not reset and not modified by the abandoned access.

## Timing
Request accepted in cycle T.
- Load: `stall`=1 in T+1..T+RD_LAT; `rvalid`=1 and new `rdata` in T+RD_LAT+1 with `stall`=0. A new request is acceptable in T+RD_LAT+1.
- Store (unbuffered): `stall`=1 in T+1; RAM is updated at the end of T+1; `stall`=0 in T+2.
- Back-to-back loads: the second load is accepted in the `rvalid` cycle of the first.
- Illegal request: `err`=1 in T+1, `stall` stays 0.

## Configuration
- `WRITE_BUF_EN` defined: a single-entry posted write buffer is present.
  - A store accepted in T goes to the buffer and does not enter WR; `stall` stays 0.
  - The buffer drains into the array at the end of T+1, unconditionally.
  - A store in T+1 refills the buffer in the same cycle it drains, so there is never a buffer-full stall.
  - A load accepted at or after T+1 samples the array no earlier than the end of T+2, so no forwarding path is needed.
  - `rst` invalidates the buffer; the pending write is lost.
- `WRITE_BUF_EN` undefined: stores use the WR state as described under Operation.

## Structure
- Shared package `cpu_mem_pkg`: FSM state enum and default DATA_W/ADDR_W/RD_LAT localparams, shared with the CPU top.
- Sub-module `mem_array`: single-port synchronous RAM with one read-or-write per cycle and no reset. It is instantiated once; the FSM, counter and buffer live in `data_mem_responder`.

## Test plan
- Reset, then store 0xDEADBEEF @0x010 (unbuffered) -> `stall`=1 exactly one cycle; later load @0x010 -> `rvalid` at T+3 with RD_LAT=2, `rdata`=0xDEADBEEF.
- Loads @0x000 then @0x3FF back-to-back with RD_LAT=1 -> `rvalid` pulses 2 cycles apart with the correct data; `rdata` holds between the pulses.
- `wmem`=`rmem`=1 @0x005 -> `err`=1 for one cycle, `stall`=0, RAM @0x005 unchanged.
- `rst` asserted in the first RD_WAIT cycle -> next cycle `stall`=0, `rvalid`=0, `rdata`=0; no `rvalid` pulse ever follows.
- `WRITE_BUF_EN`: store 0x1234 @0x020 in T, load @0x020 in T+1 -> `stall` 0 in T+1, `rdata`=0x1234 at T+RD_LAT+2.
- `WRITE_BUF_EN`: stores in T, T+1, T+2 to 0x30..0x32, then reads of all three -> all values correct, `stall` never asserted during the stores.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory path: responder FSM states and default geometry.
package cpu_mem_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 10;
    localparam int unsigned DEF_RD_LAT = 2;
    // Wide enough for the largest legal read latency (7).
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one read or one write per enabled cycle, no reset.
// The read register only updates on a read, so it holds the last loaded word.
module mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Services CPU load/store strobes against the data RAM, stalling while an access is in flight.
// Optional WRITE_BUF_EN: single-entry posted write buffer, stores complete without stalling.
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wmem,
    input  logic              rmem,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              stall,
    output logic              err
);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic              stall_q, stall_d;
    logic              err_q, err_d;
    logic              loaded_q, loaded_d;
    logic              ram_en_c, ram_we_c;
    logic [DATA_W-1:0] ram_rdata;
`ifdef WRITE_BUF_EN
    logic              buf_vld_q, buf_vld_d;
`endif

    // Next state, request capture and RAM port control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        loaded_d = loaded_q;
        ram_en_c = 1'b0;
        ram_we_c = 1'b0;
`ifdef WRITE_BUF_EN
        buf_vld_d = 1'b0;
        // A store accepted last cycle drains now; it can never collide with a read.
        if (buf_vld_q) begin
            ram_en_c = 1'b1;
            ram_we_c = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                if (wmem && rmem) begin
                    err_d = 1'b1;
                end else if (rmem) begin
                    addr_d  = addr;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = RD_WAIT;
                end else if (wmem) begin
                    addr_d  = addr;
                    wdata_d = wdata;
`ifdef WRITE_BUF_EN
                    buf_vld_d = 1'b1;
`else
                    state_d = WR;
`endif
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    ram_en_c = 1'b1;
                    rvalid_d = 1'b1;
                    loaded_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WR: begin
                ram_en_c = 1'b1;
                ram_we_c = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        stall_d = (state_d != IDLE);
        // An access abandoned by reset must leave the array and read register untouched.
        if (rst) begin
            ram_en_c = 1'b0;
            ram_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            stall_q  <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            stall_q  <= stall_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
        end
    end

`ifdef WRITE_BUF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q <= 1'b0;
        end else begin
            buf_vld_q <= buf_vld_d;
        end
    end
`endif

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem_array (
        .clk     (clk),
        .en_i    (ram_en_c),
        .we_i    (ram_we_c),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // The RAM read register has no reset; mask it until a load completes after reset.
    assign rdata  = loaded_q ? ram_rdata : '0;
    assign rvalid = rvalid_q;
    assign stall  = stall_q;
    assign err    = err_q;

endmodule
